// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Scoreboard-based hazard controller for a 5-stage RV32 pipeline. Destination
// registers of in-flight instructions are tracked internally across DEPTH
// post-ID stages (entry 0 = EX, 1 = MEM, 2 = WB). From this the unit derives
// the stall, bubble and flush controls for RAW, load-use, branch and
// memory-wait events. It also keeps saturating stall/flush event counters.
//
// Optional feature: define HAZARD_FWD_EN to enable operand forwarding. With it
// enabled, only load-use dependencies on entry 0 stall, and fwd_rsX_sel points
// at the youngest matching entry. Without it, any dependency stalls and the
// selects are tied to 0.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   id_*                 decoded ID-stage instruction (valid, sources, dest, load)
//   branch_taken         branch/jump resolved taken in EX
//   iready_n, dready_n   instruction / data memory not ready
//   dbusy, mem_rw        data write busy; MEM access type ([1] read, [0] write)
//   perf_clr             synchronous clear of both counters
//   stall_if..stall_mem  hold the respective pipeline register
//   nop_ex               insert a bubble into EX
//   flush_if, flush_id   kill IF/ID contents
//   fwd_rs1/2_sel        operand source: 0 = regfile, k = scoreboard entry k-1
//   stall_cnt, flush_cnt saturating RAW/load-use and branch-flush cycle counts

module pipe_hazard_unit #(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             branch_taken,
    input  logic             iready_n,
    input  logic             dready_n,
    input  logic             dbusy,
    input  logic [1:0]       mem_rw,
    input  logic             perf_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             nop_ex,
    output logic             flush_if,
    output logic             flush_id,
    output logic [2:0]       fwd_rs1_sel,
    output logic [2:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [DEPTH-1:0] sb_valid;
    logic [DEPTH-1:0] sb_load;
    logic [RA_W-1:0]  sb_rd [DEPTH];

    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic             mem_stall;
    logic             raw_stall;
    logic             flush_evt;
    logic             stall_evt;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = sb_valid[i] && (sb_rd[i] != '0) && (sb_rd[i] == id_rs1)
                        && id_rs1_used && id_valid;
            match2[i] = sb_valid[i] && (sb_rd[i] != '0) && (sb_rd[i] == id_rs2)
                        && id_rs2_used && id_valid;
        end
    end

    assign mem_stall = iready_n | (dready_n & mem_rw[1]) | (dbusy & mem_rw[0]);

`ifdef HAZARD_FWD_EN
    // Everything except a load still sitting in EX can be forwarded.
    assign raw_stall = (match1[0] | match2[0]) & sb_load[0];
`else
    // Without forwarding, load and ALU producers both stall until they retire.
    assign raw_stall = (|((match1 | match2) & sb_load)) |
                       (|((match1 | match2) & ~sb_load));
`endif

    // Priority: memory wait, then branch flush, then RAW bubble.
    assign flush_evt = ~mem_stall & branch_taken;
    assign stall_evt = ~mem_stall & ~branch_taken & raw_stall;

    assign stall_if  = ~rst & (mem_stall | stall_evt);
    assign stall_id  = ~rst & (mem_stall | stall_evt);
    assign stall_ex  = ~rst & mem_stall;
    assign stall_mem = ~rst & mem_stall;
    assign nop_ex    = ~rst & (flush_evt | stall_evt);
    assign flush_if  = ~rst & flush_evt;
    assign flush_id  = ~rst & flush_evt;

`ifdef HAZARD_FWD_EN
    logic [2:0] sel1;
    logic [2:0] sel2;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match1[i]) sel1 = 3'(i + 1);
            if (match2[i]) sel2 = 3'(i + 1);
        end
    end

    assign fwd_rs1_sel = (rst || nop_ex) ? 3'd0 : sel1;
    assign fwd_rs2_sel = (rst || nop_ex) ? 3'd0 : sel2;
`else
    assign fwd_rs1_sel = 3'd0;
    assign fwd_rs2_sel = 3'd0;
`endif

    // Scoreboard: frozen during memory waits, otherwise shifts every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
        end else if (!mem_stall) begin
            for (int i = 1; i < DEPTH; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_load[i]  <= sb_load[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            if (flush_evt || stall_evt) begin
                sb_valid[0] <= 1'b0;
                sb_load[0]  <= 1'b0;
                sb_rd[0]    <= '0;
            end else begin
                // x0 is never tracked: writes to it are discarded.
                sb_valid[0] <= id_valid & id_regwrite & (id_rd != '0);
                sb_load[0]  <= id_is_load;
                sb_rd[0]    <= id_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised scoreboard-based hazard controller for the 5-stage RV32 pipeline. Successor to the fixed two-stage stall/nop controller.
- Tracks in-flight destination registers internally across DEPTH post-ID stages, so the pipeline no longer feeds back per-stage write addresses.
- Generates stall, bubble and flush controls for RAW, load-use, branch and memory-wait events.
- Provides forwarding selects and saturating hazard event counters.

Parameters:
- RA_W, 5, register address width.
- DEPTH, 3, number of tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB); legal range 2..6.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  a valid instruction is in ID.
- id_rs1  in  RA_W  ID source register 1.
- id_rs2  in  RA_W  ID source register 2.
- id_rs1_used  in  1  rs1 is actually read by the instruction.
- id_rs2_used  in  1  rs2 is actually read by the instruction.
- id_rd  in  RA_W  ID destination register.
- id_regwrite  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- branch_taken  in  1  branch/jump resolved taken in EX.
- iready_n  in  1  instruction memory not ready.
- dready_n  in  1  data read not ready.
- dbusy  in  1  data write busy.
- mem_rw  in  2  MEM-stage access type: [1] read, [0] write.
- perf_clr  in  1  synchronous clear of both counters.
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the respective pipeline register.
- nop_ex  out  1  insert a bubble into EX.
- flush_if, flush_id  out  1 each  kill the IF/ID contents.
- fwd_rs1_sel  out  3  rs1 operand source; 0 = regfile, k = scoreboard entry k-1.
- fwd_rs2_sel  out  3  rs2 operand source, same encoding.
- stall_cnt  out  CNT_W  count of RAW/load-use bubble cycles.
- flush_cnt  out  CNT_W  count of branch flush cycles.

Behaviour:
- **Scoreboard state:** DEPTH entries of {valid, rd, is_load}.
- **Match definition:** entry i matches rsX when all of:
  - entry valid;
  - rd != 0;
  - rd == rsX;
  - id_rsX_used && id_valid.
- **Memory stall:** mem_stall = iready_n | (dready_n & mem_rw[1]) | (dbusy & mem_rw[0]).
- **raw_stall, without forwarding:** any match in any entry.
- **raw_stall, with forwarding:** see Optional Feature.
- **Priority:** rst > mem_stall > branch_taken > raw_stall > normal. All outputs are combinational from state and inputs.
- **mem_stall:**
  - stall_if, stall_id, stall_ex and stall_mem = 1.
  - nop_ex, flush_if and flush_id = 0.
  - Scoreboard frozen; counters unchanged.
  - A pending branch_taken is honoured in the first cycle after mem_stall drops.
- **branch_taken:**
  - flush_if = flush_id = nop_ex = 1; stalls = 0.
  - Scoreboard shifts (entry[i] <= entry[i-1]); entry0 <= bubble.
  - flush_cnt +1.
- **raw_stall:**
  - stall_if = stall_id = nop_ex = 1.
  - Scoreboard shifts; entry0 <= bubble.
  - stall_cnt +1.
  - Released the cycle the producer ages out of the stalling window. Without forwarding, a dependency on EX costs exactly DEPTH bubbles.
- **Normal:**
  - All controls 0.
  - Scoreboard shifts; entry0 <= {id_valid & id_regwrite & (id_rd != 0), id_rd, id_is_load}.
  - The oldest entry retires. The register file writes in the first half-cycle, so no WB-to-ID hazard remains beyond entry DEPTH-1.
- **Counters:**
  - Saturate at all ones (no wrap).
  - perf_clr has priority over increment and clears both to 0 on the next edge.
- **Reset (rst high, asynchronous):**
  - All entries invalid; both counters 0.
  - All stall, nop and flush outputs forced 0; fwd selects forced 0 while rst is high.
- **Boundaries:**
  - rd = 0 never tracked.
  - Both sources matching different entries are resolved independently.
  - id_valid = 0 never stalls.
  - Reset mid-stall drops all controls immediately.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- **Defined:**
  - raw_stall only when entry0 matches with is_load = 1 (load-use, 1 bubble).
  - fwd_rsX_sel = 1 + index of the youngest (lowest index) matching entry, or 0 if none.
  - Selects are valid in the normal cycle and forced 0 while nop_ex = 1.
- **Undefined:**
  - Any match stalls.
  - fwd selects tied to 0; the forwarding mux is absent.

Test Plan:
- ADD x5 issued then ADD x6,x5,x1 next cycle, no fwd → stall_id = nop_ex = 1 for 3 cycles, then issue; stall_cnt = 3.
- Same sequence with HAZARD_FWD_EN → no stall; fwd_rs1_sel = 1 in the consumer's ID cycle, fwd_rs2_sel = 0.
- LW x7 then ADD x8,x7,x7 with HAZARD_FWD_EN → 1 bubble; then fwd_rs1_sel = fwd_rs2_sel = 2; stall_cnt = 1.
- branch_taken while a RAW stall is pending → flush_if = flush_id = nop_ex = 1, stall_id = 0; flush_cnt = 1; stall_cnt unchanged.
- dready_n = 1 with mem_rw = 2'b10 for 4 cycles while branch_taken = 1 → all four stalls high, flush 0 for 4 cycles, then flush for 1 cycle; scoreboard unchanged across the wait.
- Write x0 followed by a reader of x0 → no stall. Drive stall_cnt to 16'hFFFF then stall again → stays FFFF; perf_clr → 0. Assert rst mid-stall → all outputs 0 immediately.
